// File: rtl/display_pkg.sv
// Shared types for the two-digit display multiplexer.
package display_pkg;

  localparam int DIGITS = 2;

  typedef logic [3:0] hex_t;

  typedef enum logic [1:0] {
    BLANK0,
    SHOW0,
    BLANK1,
    SHOW1
  } mux_state_t;

endpackage

// File: rtl/refresh_counter.sv
// Slot timer for the display multiplexer: owns the slot counter and digit select,
// and presents the state the next clock edge will enter.
module refresh_counter
  import display_pkg::*;
#(
  parameter int  REFRESH_CYCLES = 24000,
  parameter int  BLANK_CYCLES   = 480,
  localparam int CNT_W          = $clog2(REFRESH_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  output logic       digit_sel,
  output mux_state_t next_state,
  output logic       next_frame
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             sel_next;
  logic             last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      digit_sel <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      digit_sel <= sel_next;
    end
  end

  // The state is purely a decode of where the counter lands next, so the
  // registered outputs downstream line up with the cnt/digit_sel they display.
  always_comb begin
    last       = (cnt == CNT_W'(REFRESH_CYCLES - 1));
    cnt_next   = last ? '0 : cnt + 1'b1;
    sel_next   = digit_sel ^ last;
    next_frame = last & digit_sel;
    next_state = BLANK0;
    if (cnt_next < CNT_W'(BLANK_CYCLES)) begin
      next_state = sel_next ? BLANK1 : BLANK0;
    end else begin
      next_state = sel_next ? SHOW1 : SHOW0;
    end
  end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexes two hex digits onto one segment decoder with a blanking gap per slot.
// Define DISPLAY_MUX_LZB_EN to suppress digit 1 while it holds a leading zero.
module display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 480
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  hex_t s0,
  input  hex_t s1,
  output hex_t s,
  output logic an0_n,
  output logic an1_n,
  output logic digit_sel,
  output logic frame_tick
);

  mux_state_t next_state;
  logic       next_frame;
  hex_t       digits [DIGITS];
  hex_t       s_next;
  logic       an0_next;
  logic       an1_next;
  logic       lit1_ok;

  refresh_counter #(
    .REFRESH_CYCLES(REFRESH_CYCLES),
    .BLANK_CYCLES  (BLANK_CYCLES)
  ) u_refresh (
    .clk       (clk),
    .reset     (reset),
    .digit_sel (digit_sel),
    .next_state(next_state),
    .next_frame(next_frame)
  );

  assign digits[0] = s0;
  assign digits[1] = s1;

`ifdef DISPLAY_MUX_LZB_EN
  assign lit1_ok = (s != 4'h0);
`else
  assign lit1_ok = 1'b1;
`endif

  // s tracks the owning digit only while blanked, so it is stable before the digit lights.
  always_comb begin
    s_next   = s;
    an0_next = 1'b1;
    an1_next = 1'b1;
    case (next_state)
      BLANK0:  s_next   = digits[0];
      BLANK1:  s_next   = digits[1];
      SHOW0:   an0_next = ~en;
      SHOW1:   an1_next = ~(en & lit1_ok);
      default: s_next   = s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s          <= 4'h0;
      an0_n      <= 1'b1;
      an1_n      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      s          <= s_next;
      an0_n      <= an0_next;
      an1_n      <= an1_next;
      frame_tick <= next_frame;
    end
  end

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux with a short slot (8 cycles, 2 blanked).
module tb_display_mux;

  localparam int REFRESH = 8;
  localparam int BLANK   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [3:0] s0 = 4'h0;
  logic [3:0] s1 = 4'h0;
  logic [3:0] s;
  logic       an0_n;
  logic       an1_n;
  logic       digit_sel;
  logic       frame_tick;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] expQ [$];
  int         mcnt;
  logic       msel;
  logic [3:0] ms;

  display_mux #(
    .REFRESH_CYCLES(REFRESH),
    .BLANK_CYCLES  (BLANK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .s0        (s0),
    .s1        (s1),
    .s         (s),
    .an0_n     (an0_n),
    .an1_n     (an1_n),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    mcnt = 0;
    msel = 1'b0;
    ms   = 4'h0;
    expQ.delete();
  endtask

  // Predict the outputs after the coming edge, then compare them once it has passed.
  task automatic applyStimulus();
    logic [7:0] expVal;
    logic [7:0] got;
    logic       wrap;
    logic       blank;
    logic       an0;
    logic       an1;
    logic       ft;
    wrap  = (mcnt == REFRESH - 1);
    ft    = wrap && msel;
    mcnt  = wrap ? 0 : mcnt + 1;
    msel  = msel ^ wrap;
    blank = (mcnt < BLANK);
    if (blank) ms = msel ? s1 : s0;
    an0 = !(!blank && !msel && en);
    an1 = !(!blank && msel && en);
`ifdef DISPLAY_MUX_LZB_EN
    if (ms == 4'h0) an1 = 1'b1;
`endif
    expQ.push_back({ms, an0, an1, msel, ft});
    @(posedge clk);
    #1;
    got    = {s, an0_n, an1_n, digit_sel, frame_tick};
    expVal = expQ.pop_front();
    checkOutput("scoreboard", got, expVal);
    checkOutput("enables_exclusive", 8'(an0_n | an1_n), 8'd1);
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b0;
    modelReset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    s0 = 4'h3;
    s1 = 4'hA;
    en = 1'b1;
    modelReset();
    #12;
    checkOutput("reset_state", {s, an0_n, an1_n, digit_sel, frame_tick}, 8'b0000_1100);
    @(negedge clk);
    reset = 1'b1;

    // Basic slot sequencing, frame pulse, and input changes hidden during SHOW0.
    for (int e = 1; e <= 32; e++) begin
      applyStimulus();
      if (e == 1) checkOutput("s_first_blank", 8'(s), 8'h3);
      if (e >= 2 && e <= 7) checkOutput("an0_show0", 8'(an0_n), 8'd0);
      if (e >= 4 && e <= 7) checkOutput("s_held_show0", 8'(s), 8'h3);
      if (e == 8) checkOutput("slot1_entry", {3'b0, an0_n, s}, {3'b0, 1'b1, 4'hA});
      if (e == 8) checkOutput("digit_sel_slot1", 8'(digit_sel), 8'd1);
      if (e >= 10 && e <= 15) checkOutput("an1_show1", 8'(an1_n), 8'd0);
      checkOutput("frame_tick", 8'(frame_tick), 8'((e % 16) == 0));
      if (e == 17) checkOutput("s_new_blank0", 8'(s), 8'h7);
      if (e == 4) s0 = 4'h7;
    end

    // Display enable gating with preserved phase.
    s0 = 4'h3;
    s1 = 4'hA;
    en = 1'b1;
    resetDut();
    for (int e = 1; e <= 20; e++) begin
      applyStimulus();
      if (e == 4) checkOutput("en_off_an0", 8'(an0_n), 8'd1);
      if (e == 13) checkOutput("en_on_an1", 8'(an1_n), 8'd0);
      if (e == 16) checkOutput("en_frame_tick", 8'(frame_tick), 8'd1);
      if (e == 3) en = 1'b0;
      if (e == 12) en = 1'b1;
    end

    // Asynchronous reset while digit 1 is lit.
    resetDut();
    for (int e = 1; e <= 13; e++) applyStimulus();
    checkOutput("pre_reset_an1", 8'(an1_n), 8'd0);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", {s, an0_n, an1_n, digit_sel, frame_tick}, 8'b0000_1100);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      applyStimulus();
      if (e == 2) checkOutput("restart_an0", 8'(an0_n), 8'd0);
    end

    // Leading zero on digit 1.
    s0 = 4'h5;
    s1 = 4'h0;
    resetDut();
    for (int e = 1; e <= 16; e++) begin
      applyStimulus();
      if (e >= 2 && e <= 7) checkOutput("lz_an0_show0", 8'(an0_n), 8'd0);
`ifdef DISPLAY_MUX_LZB_EN
      if (e >= 10 && e <= 15) checkOutput("lz_an1_blanked", 8'(an1_n), 8'd1);
`else
      if (e >= 10 && e <= 15) checkOutput("lz_an1_lit", 8'(an1_n), 8'd0);
`endif
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
